rv_inst_encoder: RTL and testbench
==================================

Name: rv_inst_encoder

Overview:
- Instruction encoder: the write-side counterpart of the single-cycle control-unit decoder.
- Accepts symbolic instruction requests (operation code, rd, rs1, rs2, immediate) over a valid/ready handshake.
- Emits packed RV32I/RV32M machine words, each with a word address, into an output FIFO that feeds the instruction-memory loader.
- Expands the LI pseudo-op into LUI+ADDI with a small FSM; flags and drops illegal requests.

Parameters:
- DEPTH, 4, output FIFO depth in words (power of 2, >=2).
- BASE, 32'h0000_0000, address of the first emitted word.

Ports:
- clk  input  1  clock, rising edge.
- clrn  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid & in_ready.
- in_op  input  5  op select: 0 lui, 1 jal, 2 jalr, 3 beq, 4 bne, 5 lw, 6 sw, 7 addi, 8 xori, 9 ori, 10 andi, 11 slli, 12 srli, 13 srai, 14 add, 15 sub, 16 slt, 17 xor, 18 or, 19 and, 20 mul, 21 mulh, 22 mulhsu, 23 mulhu, 24 div, 25 divu, 26 rem, 27 remu, 28 li, 29 nop; 30-31 illegal.
- in_rd / in_rs1 / in_rs2  input  5 each  register fields.
- in_imm  input  32  immediate. lui: U field = in_imm[19:0]. Others: signed byte offset / value.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer pops head when out_valid & out_ready.
- out_inst  output  32  encoded word at FIFO head.
- out_addr  output  32  address of out_inst.
- err  output  1  one-cycle pulse on a dropped request.
- err_cnt  output  8  saturating count of dropped requests.

Behaviour:
- Reset (clrn low, async): FIFO empty, out_valid=0, out_inst=0, out_addr=BASE, state=IDLE, err=0, err_cnt=0. A reset mid-expansion discards the pending second word.
- Encoding per RV32 spec. Field placement:
  - I-type (addi/xori/ori/andi/lw/jalr): imm[11:0].
  - S-type (sw): imm[11:5] / imm[4:0].
  - B-type (beq/bne): imm[12|10:5|4:1|11].
  - J-type (jal): imm[20|10:1|11|19:12].
  - Shifts: shamt imm[4:0], func7 0100000 for srai only.
  - R-type: func7 0000000 / 0100000 (sub) / 0000001 (M ops).
- nop = 0x00000013.
- Range checks; a failing check makes the request illegal:
  - I/S: imm must be sign-extension of 12 bits.
  - B: sign-extension of 13 bits and imm[0]=0.
  - J: sign-extension of 21 bits and imm[0]=0.
  - shifts: imm[31:5]=0.
  - lui: imm[31:20]=0.
- Illegal request (bad op or range): accepted (in_ready handshake completes), nothing written, err=1 the next cycle, err_cnt+1 saturating at 255. Address does not advance.
- Latency: accepted word is in the FIFO and visible on out_* the cycle after acceptance when the FIFO was empty.
- in_ready = (state==IDLE) & FIFO not full.
- out_addr increments by 4 per word pushed. Each FIFO entry stores its own address; out_addr shows the head entry's address, BASE when empty.
- Simultaneous push and pop when full: push blocked by in_ready. When empty, a pop is ignored.
- FSM states: IDLE, LI2.
  - li with imm fitting 12 bits signed: single word addi rd,x0,imm. Stay IDLE.
  - Otherwise push lui rd,hi with hi=(imm+0x800)>>12 (32-bit wrap).
  - If imm[11:0]!=0, go to LI2 and latch rd/lo. In LI2, push addi rd,rd,lo when FIFO not full, then return to IDLE. in_ready=0 throughout LI2.
  - If imm[11:0]==0, no second word.
- rd=0 is legal and encoded as-is.

Optional Feature:
- RV32M_EN: defined -> ops 20-27 encoded with func7 0000001 and func3 = op-20.
- Undefined -> ops 20-27 treated as illegal (err pulse, err_cnt+1, no word).

Test Plan:
- addi rd=1 rs1=0 imm=5 -> out_inst 0x00500093, out_addr BASE; add rd=3 rs1=1 rs2=2 -> 0x002081B3, addr BASE+4.
- beq rs1=1 rs2=2 imm=8 -> 0x00208463. beq imm=7 -> err pulse, err_cnt=1, no word.
- li rd=5 imm=0x12345678 -> 0x123452B7 then 0x67828293, in_ready low one cycle. li rd=6 imm=0xFFF -> 0x00001337 then 0xFFF30313.
- mul rd=1 rs1=2 rs2=3:
  - with RV32M_EN -> 0x023100B3.
  - without -> err, err_cnt increments.
- Hold out_ready=0, push DEPTH words -> in_ready falls after DEPTH words. Release -> words drain in order with ascending addresses.
- Assert clrn low after li's lui is pushed, while in LI2 -> FIFO empty, out_addr=BASE, addi never emitted, state IDLE.

Source files
------------

// File: rtl/rv_inst_encoder.sv
// rv_inst_encoder: turns symbolic RV32 instruction requests into machine words plus word
// addresses, buffered in an output FIFO. Define RV32M_EN to encode M-extension ops 20-27.
module rv_inst_encoder #(
  parameter int unsigned DEPTH = 4,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [7:0]  err_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_REG    = 7'b0110011;

  typedef enum logic {IDLE, LI2} state_t;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_REG};
  endfunction

  state_t        state;
  logic [4:0]    li_rd;
  logic [11:0]   li_lo;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   next_addr;
  logic [31:0]   mem_inst [DEPTH];
  logic [31:0]   mem_addr [DEPTH];

  logic          fits12, fits13, fits21, shamt_ok, lui_ok;
  logic [19:0]   li_hi;
  logic [31:0]   enc_word, push_word;
  logic          enc_legal, li_two;
  logic [PW-1:0] fifo_cnt;
  logic          full, empty, accept, push_en, pop_en;

  // Immediate range checks: upper bits must be pure sign extension.
  assign fits12   = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
  assign fits13   = (in_imm[31:12] == '0) || (in_imm[31:12] == '1);
  assign fits21   = (in_imm[31:20] == '0) || (in_imm[31:20] == '1);
  assign shamt_ok = (in_imm[31:5] == '0);
  assign lui_ok   = (in_imm[31:20] == '0);
  // Rounded upper part so that lui hi + sign-extended lo reproduces the value.
  assign li_hi    = 20'((in_imm + 32'h0000_0800) >> 12);

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b0;
    li_two    = 1'b0;
    case (in_op)
      5'd0: begin
        enc_legal = lui_ok;
        enc_word  = {in_imm[19:0], in_rd, OPC_LUI};
      end
      5'd1: begin
        enc_legal = fits21 & ~in_imm[0];
        enc_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
      end
      5'd2: begin
        enc_legal = fits12;
        enc_word  = enc_i(in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR);
      end
      5'd3, 5'd4: begin
        enc_legal = fits13 & ~in_imm[0];
        enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, {2'b00, in_op == 5'd4},
                     in_imm[4:1], in_imm[11], OPC_BRANCH};
      end
      5'd5: begin
        enc_legal = fits12;
        enc_word  = enc_i(in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_LOAD);
      end
      5'd6: begin
        enc_legal = fits12;
        enc_word  = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OPC_STORE};
      end
      5'd7: begin
        enc_legal = fits12;
        enc_word  = enc_i(in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_IMM);
      end
      5'd8: begin
        enc_legal = fits12;
        enc_word  = enc_i(in_imm[11:0], in_rs1, 3'b100, in_rd, OPC_IMM);
      end
      5'd9: begin
        enc_legal = fits12;
        enc_word  = enc_i(in_imm[11:0], in_rs1, 3'b110, in_rd, OPC_IMM);
      end
      5'd10: begin
        enc_legal = fits12;
        enc_word  = enc_i(in_imm[11:0], in_rs1, 3'b111, in_rd, OPC_IMM);
      end
      5'd11: begin
        enc_legal = shamt_ok;
        enc_word  = enc_i({7'b0000000, in_imm[4:0]}, in_rs1, 3'b001, in_rd, OPC_IMM);
      end
      5'd12: begin
        enc_legal = shamt_ok;
        enc_word  = enc_i({7'b0000000, in_imm[4:0]}, in_rs1, 3'b101, in_rd, OPC_IMM);
      end
      5'd13: begin
        enc_legal = shamt_ok;
        enc_word  = enc_i({7'b0100000, in_imm[4:0]}, in_rs1, 3'b101, in_rd, OPC_IMM);
      end
      5'd14: begin
        enc_legal = 1'b1;
        enc_word  = enc_r(7'b0000000, in_rs2, in_rs1, 3'b000, in_rd);
      end
      5'd15: begin
        enc_legal = 1'b1;
        enc_word  = enc_r(7'b0100000, in_rs2, in_rs1, 3'b000, in_rd);
      end
      5'd16: begin
        enc_legal = 1'b1;
        enc_word  = enc_r(7'b0000000, in_rs2, in_rs1, 3'b010, in_rd);
      end
      5'd17: begin
        enc_legal = 1'b1;
        enc_word  = enc_r(7'b0000000, in_rs2, in_rs1, 3'b100, in_rd);
      end
      5'd18: begin
        enc_legal = 1'b1;
        enc_word  = enc_r(7'b0000000, in_rs2, in_rs1, 3'b110, in_rd);
      end
      5'd19: begin
        enc_legal = 1'b1;
        enc_word  = enc_r(7'b0000000, in_rs2, in_rs1, 3'b111, in_rd);
      end
`ifdef RV32M_EN
      5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26, 5'd27: begin
        enc_legal = 1'b1;
        enc_word  = enc_r(7'b0000001, in_rs2, in_rs1, 3'(in_op - 5'd20), in_rd);
      end
`endif
      5'd28: begin
        enc_legal = 1'b1;
        if (fits12) begin
          enc_word = enc_i(in_imm[11:0], 5'd0, 3'b000, in_rd, OPC_IMM);
        end else begin
          enc_word = {li_hi, in_rd, OPC_LUI};
          li_two   = (in_imm[11:0] != '0);
        end
      end
      5'd29: begin
        enc_legal = 1'b1;
        enc_word  = 32'h0000_0013;
      end
      default: begin
        enc_legal = 1'b0;
        enc_word  = '0;
      end
    endcase
  end

  assign fifo_cnt  = wr_ptr - rd_ptr;
  assign full      = (fifo_cnt == PW'(DEPTH));
  assign empty     = (wr_ptr == rd_ptr);
  assign in_ready  = (state == IDLE) & ~full;
  assign accept    = in_valid & in_ready;
  assign pop_en    = ~empty & out_ready;
  // In LI2 the pending addi goes in as soon as there is room.
  assign push_en   = (state == IDLE) ? (accept & enc_legal) : ~full;
  assign push_word = (state == LI2) ? enc_i(li_lo, li_rd, 3'b000, li_rd, OPC_IMM) : enc_word;

  assign out_valid = ~empty;
  assign out_inst  = empty ? '0   : mem_inst[rd_ptr[AW-1:0]];
  assign out_addr  = empty ? BASE : mem_addr[rd_ptr[AW-1:0]];

  // FIFO storage carries no reset; pointers alone define what is visible.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_inst[wr_ptr[AW-1:0]] <= push_word;
      mem_addr[wr_ptr[AW-1:0]] <= next_addr;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= IDLE;
      li_rd     <= '0;
      li_lo     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      next_addr <= BASE;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err <= 1'b0;
      if (push_en) begin
        wr_ptr    <= wr_ptr + PW'(1);
        next_addr <= next_addr + 32'd4;
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case (state)
        IDLE: begin
          if (accept) begin
            if (!enc_legal) begin
              err <= 1'b1;
              if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
              end
            end else if (li_two) begin
              state <= LI2;
              li_rd <= in_rd;
              li_lo <= in_imm[11:0];
            end
          end
        end
        LI2: begin
          if (!full) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_inst_encoder.sv
// Self-checking bench for rv_inst_encoder: directed cases plus randomized requests
// compared against an arithmetic reference encoder and an expected-word queue.
module tb_rv_inst_encoder;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        clrn;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op, in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst, out_addr;
  logic        err;
  logic [7:0]  err_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_addr = BASE;
  int          mcnt     = 0;
  logic [63:0] mon_e;

  rv_inst_encoder #(.DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk(clk), .clrn(clrn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr),
    .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference encoder built from field arithmetic on the RV32 formats.
  function automatic bit fits(input logic [31:0] imm, input int bits);
    longint s, lim;
    s   = longint'($signed(imm));
    lim = longint'(1) << (bits - 1);
    return (s >= -lim) && (s < lim);
  endfunction

  function automatic logic [31:0] f_i(input logic [31:0] imm, input logic [31:0] rs1,
                                      input logic [31:0] f3, input logic [31:0] rd,
                                      input logic [31:0] opc);
    return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
  endfunction

  function automatic logic [31:0] f_r(input logic [31:0] f7, input logic [31:0] rs2,
                                      input logic [31:0] rs1, input logic [31:0] f3,
                                      input logic [31:0] rd);
    return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
  endfunction

  function automatic void model(input logic [31:0] op, input logic [31:0] rd,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] imm, output bit legal, output int nw,
                                output logic [31:0] w0, output logic [31:0] w1);
    logic [31:0] f3, hi;
    legal = 1'b0; nw = 0; w0 = '0; w1 = '0; f3 = '0;
    if (op == 0) begin
      legal = imm < 32'h0010_0000;
      w0 = ((imm & 32'hFFFFF) << 12) | (rd << 7) | 32'h37;
    end else if (op == 1) begin
      legal = fits(imm, 21) && (imm % 2 == 0);
      w0 = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
           (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
    end else if (op == 2) begin
      legal = fits(imm, 12); w0 = f_i(imm, rs1, 0, rd, 32'h67);
    end else if (op == 3 || op == 4) begin
      legal = fits(imm, 13) && (imm % 2 == 0);
      w0 = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20) |
           (rs1 << 15) | ((op - 3) << 12) | (((imm >> 1) & 32'hF) << 8) |
           (((imm >> 11) & 1) << 7) | 32'h63;
    end else if (op == 5) begin
      legal = fits(imm, 12); w0 = f_i(imm, rs1, 2, rd, 32'h03);
    end else if (op == 6) begin
      legal = fits(imm, 12);
      w0 = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12) |
           ((imm & 32'h1F) << 7) | 32'h23;
    end else if (op >= 7 && op <= 10) begin
      f3 = (op == 7) ? 0 : (op == 8) ? 4 : (op == 9) ? 6 : 7;
      legal = fits(imm, 12); w0 = f_i(imm, rs1, f3, rd, 32'h13);
    end else if (op >= 11 && op <= 13) begin
      f3 = (op == 11) ? 1 : 5;
      legal = imm < 32;
      w0 = f_i(imm + ((op == 13) ? 32'h400 : 32'h0), rs1, f3, rd, 32'h13);
    end else if (op >= 14 && op <= 19) begin
      f3 = (op <= 15) ? 0 : (op == 16) ? 2 : (op == 17) ? 4 : (op == 18) ? 6 : 7;
      legal = 1'b1; w0 = f_r((op == 15) ? 32'h20 : 32'h0, rs2, rs1, f3, rd);
    end else if (op >= 20 && op <= 27) begin
`ifdef RV32M_EN
      legal = 1'b1; w0 = f_r(1, rs2, rs1, op - 20, rd);
`else
      legal = 1'b0;
`endif
    end else if (op == 28) begin
      legal = 1'b1;
      if (fits(imm, 12)) begin
        w0 = f_i(imm, 0, 0, rd, 32'h13);
      end else begin
        hi = (imm + 32'h800) >> 12;
        w0 = (hi << 12) | (rd << 7) | 32'h37;
        if ((imm & 32'hFFF) != 0) begin
          w1 = f_i(imm, rd, 0, rd, 32'h13);
          nw = 2;
        end
      end
    end else if (op == 29) begin
      legal = 1'b1; w0 = 32'h13;
    end
    if (legal && nw == 0) nw = 1;
    if (!legal) nw = 0;
  endfunction

  task automatic push_exp(input logic [31:0] w);
    exp_q.push_back({exp_addr, w});
    exp_addr += 32'd4;
  endtask

  // Called at posedge+2; returns at posedge+2.
  task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    bit legal;
    int nw, waited;
    logic [31:0] w0, w1;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("accept_wait", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      @(posedge clk); #2;
      return;
    end
    @(posedge clk);
    model(32'(op), 32'(rd), 32'(rs1), 32'(rs2), imm, legal, nw, w0, w1);
    if (legal) begin
      push_exp(w0);
      if (nw == 2) push_exp(w1);
    end else if (mcnt < 255) begin
      mcnt++;
    end
    #2 in_valid = 1'b0;
    if (nw == 2) check("li_busy", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("err", 32'(err), legal ? 32'd0 : 32'd1);
    check("err_cnt", 32'(err_cnt), 32'(mcnt));
    @(posedge clk); #2;
  endtask

  task automatic pop_expect(input logic [31:0] inst, input logic [31:0] addr);
    check("head_vld", 32'(out_valid), 32'd1);
    check("head_inst", out_inst, inst);
    check("head_addr", out_addr, addr);
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
  endtask

  // Consumer side: every pop must match the oldest expected word.
  always @(negedge clk) begin
    if (clrn) begin
      check("out_vld", 32'(out_valid), 32'(exp_q.size() != 0));
      if (!out_valid) check("addr_empty", out_addr, BASE);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("pop_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("pop_inst", out_inst, mon_e[31:0]);
          check("pop_addr", out_addr, mon_e[63:32]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] imm, bl[10];
    int waited;
    bl = '{32'h0000_07FF, 32'hFFFF_F800, 32'h0000_0800, 32'hFFFF_F7FF, 32'h0000_0FFE,
           32'hFFFF_F000, 32'h000F_FFFE, 32'hFFF0_0000, 32'h0010_0000, 32'h000F_FFFF};
    clrn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    #12;
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_inst", out_inst, 32'd0);
    check("rst_addr", out_addr, BASE);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #2;
    clrn = 1'b1;
    check("rst_rdy", 32'(in_ready), 32'd1);

    send(5'd7, 5'd1, 5'd0, 5'd0, 32'd5);
    send(5'd14, 5'd3, 5'd1, 5'd2, 32'd0);
    pop_expect(32'h0050_0093, BASE);
    pop_expect(32'h0020_81B3, BASE + 32'd4);
    send(5'd3, 5'd0, 5'd1, 5'd2, 32'd8);
    pop_expect(32'h0020_8463, BASE + 32'd8);
    send(5'd3, 5'd0, 5'd1, 5'd2, 32'd7);
    check("beq_odd_cnt", 32'(err_cnt), 32'd1);
    send(5'd28, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
    pop_expect(32'h1234_52B7, BASE + 32'd12);
    pop_expect(32'h6782_8293, BASE + 32'd16);
    send(5'd28, 5'd6, 5'd0, 5'd0, 32'h0000_0FFF);
    pop_expect(32'h0000_1337, BASE + 32'd20);
    pop_expect(32'hFFF3_0313, BASE + 32'd24);
    send(5'd20, 5'd1, 5'd2, 5'd3, 32'd0);
`ifdef RV32M_EN
    pop_expect(32'h0231_00B3, BASE + 32'd28);
`else
    check("mul_cnt", 32'(err_cnt), 32'd2);
`endif

    // Fill with the consumer stalled, then drain.
    for (int i = 0; i < DEPTH; i++) send(5'd29, 5'd0, 5'd0, 5'd0, 32'd0);
    check("full_rdy", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    repeat (DEPTH + 1) @(posedge clk);
    #2;
    check("drained_vld", 32'(out_valid), 32'd0);

    // Reset while the li second word is pending.
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 5'd28; in_rd = 5'd7; in_rs1 = '0; in_rs2 = '0;
    in_imm = 32'h1234_5678;
    @(negedge clk);
    check("li_rst_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #2;
    in_valid = 1'b0;
    check("li_rst_busy", 32'(in_ready), 32'd0);
    check("li_rst_lui", 32'(out_valid), 32'd1);
    clrn = 1'b0;
    exp_q.delete(); exp_addr = BASE; mcnt = 0;
    #1;
    check("mid_rst_vld", 32'(out_valid), 32'd0);
    check("mid_rst_addr", out_addr, BASE);
    check("mid_rst_cnt", 32'(err_cnt), 32'd0);
    check("mid_rst_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #2;
    clrn = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("no_addi", 32'(out_valid), 32'd0);

    // Randomized requests with a randomly stalling consumer.
    for (int n = 0; n < 300; n++) begin
      out_ready = (exp_q.size() >= DEPTH) ? 1'b1 : ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 4))
        0: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        1: imm = $urandom;
        2: imm = (32'($urandom_range(0, 8191)) - 32'd4096) & 32'hFFFF_FFFE;
        3: imm = 32'($urandom_range(0, 63));
        default: imm = bl[$urandom_range(0, 9)];
      endcase
      send(5'($urandom_range(0, 31)), 5'($urandom), 5'($urandom), 5'($urandom), imm);
    end

    // Saturate the error counter.
    out_ready = 1'b1;
    for (int n = 0; n < 260; n++) send(5'd31, 5'd0, 5'd0, 5'd0, 32'd0);
    check("sat_cnt", 32'(err_cnt), 32'd255);

    waited = 0;
    while ((exp_q.size() != 0 || out_valid) && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    #2;
    check("final_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
